// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported, multi-cycle unified memory between the fetch
//   stage (instruction reads) and the memory stage (data reads/writes).
//   Only one access is outstanding at a time. The data port has fixed
//   priority over fetch because it always belongs to the older instruction.
//   An in-flight fetch can be squashed by flush_fetch: its completion is
//   absorbed and produces no if_valid.
//
// Ports
//   clk, rst        system clock, synchronous active-high reset
//   if_req/if_addr  fetch request and PC
//   flush_fetch     squash the current or pending fetch
//   dm_rd/dm_wr     data read / write request (mutually exclusive)
//   dm_addr/dm_wdata data address and store data
//   if_data/if_valid instruction word and one-cycle completion pulse
//   dm_rdata/dm_valid load data and one-cycle completion pulse
//   stall_fetch     fetch must hold PC and IF/ID
//   stall_mem       memory stage and everything upstream must hold
//   m_addr/m_wdata  memory command address / write data
//   m_rd/m_wr       one-cycle memory read / write command
//   m_busy          memory cannot accept a command this cycle
//   m_done/m_rdata  one-cycle completion pulse and read data from memory
module mem_port_arbiter #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              flush_fetch,
  input  logic              dm_rd,
  input  logic              dm_wr,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] if_data,
  output logic              if_valid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              stall_fetch,
  output logic              stall_mem,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic              m_rd,
  output logic              m_wr,
  input  logic              m_busy,
  input  logic              m_done,
  input  logic [DATA_W-1:0] m_rdata
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BUSY_I = 2'd1,
    S_BUSY_D = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_drop;
  logic [ADDR_W-1:0]   r_cmd_addr;
  logic [DATA_W-1:0]   r_cmd_wdata;
  logic                r_cmd_is_wr;

  logic w_dm_req;
  logic w_issue_d;
  logic w_issue_i;
  logic w_if_done;
  logic w_dm_done;

  // Issue decisions are made combinationally so a command leaves in the
  // same cycle the request is seen in IDLE.
  always_comb begin
    w_dm_req  = dm_rd | dm_wr;
    w_issue_d = (r_state == S_IDLE) && !m_busy && w_dm_req;
    w_issue_i = (r_state == S_IDLE) && !m_busy && !w_dm_req &&
                if_req && !flush_fetch;
    // A flush arriving in the very cycle of m_done still kills the result.
    w_if_done = (r_state == S_BUSY_I) && m_done && !(r_drop || flush_fetch);
    w_dm_done = (r_state == S_BUSY_D) && m_done;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_drop      <= 1'b0;
      r_cmd_addr  <= '0;
      r_cmd_wdata <= '0;
      r_cmd_is_wr <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_issue_d) begin
            r_state     <= S_BUSY_D;
            r_cmd_addr  <= dm_addr;
            r_cmd_wdata <= dm_wr ? dm_wdata : '0;
            r_cmd_is_wr <= dm_wr;
          end else if (w_issue_i) begin
            r_state     <= S_BUSY_I;
            r_drop      <= 1'b0;
            r_cmd_addr  <= if_addr;
            r_cmd_wdata <= '0;
            r_cmd_is_wr <= 1'b0;
          end
        end
        S_BUSY_I: begin
          if (flush_fetch) begin
            r_drop <= 1'b1;
          end
          if (m_done) begin
            r_state <= S_IDLE;
          end
        end
        S_BUSY_D: begin
          if (m_done) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Outputs are forced to zero while reset is held so the pipeline and the
  // memory see no stalls and no commands during reset.
  always_comb begin
    if_data     = '0;
    if_valid    = 1'b0;
    dm_rdata    = '0;
    dm_valid    = 1'b0;
    stall_fetch = 1'b0;
    stall_mem   = 1'b0;
    m_addr      = '0;
    m_wdata     = '0;
    m_rd        = 1'b0;
    m_wr        = 1'b0;
    if (!rst) begin
      if (w_issue_d) begin
        m_rd    = dm_rd;
        m_wr    = dm_wr;
        m_addr  = dm_addr;
        m_wdata = dm_wr ? dm_wdata : '0;
      end else if (w_issue_i) begin
        m_rd    = 1'b1;
        m_addr  = if_addr;
      end else if (r_state != S_IDLE) begin
        m_addr  = r_cmd_addr;
        m_wdata = r_cmd_wdata;
      end

      if_valid = w_if_done;
      if_data  = w_if_done ? m_rdata : '0;
      dm_valid = w_dm_done;
      dm_rdata = (w_dm_done && !r_cmd_is_wr) ? m_rdata : '0;

      stall_mem   = w_dm_req && !w_dm_done;
      stall_fetch = (if_req && !w_if_done) || (w_dm_req && !w_dm_done);
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter. Inputs change 1 ns after the
// rising edge; outputs are sampled on the falling edge.
module tb_mem_port_arbiter;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 16;

  logic              clk;
  logic              rst;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              flush_fetch;
  logic              dm_rd;
  logic              dm_wr;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] if_data;
  logic              if_valid;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_valid;
  logic              stall_fetch;
  logic              stall_mem;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic              m_rd;
  logic              m_wr;
  logic              m_busy;
  logic              m_done;
  logic [DATA_W-1:0] m_rdata;

  int unsigned n_checks;
  int unsigned n_errors;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .flush_fetch(flush_fetch),
    .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .if_data(if_data), .if_valid(if_valid),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid),
    .stall_fetch(stall_fetch), .stall_mem(stall_mem),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_rd(m_rd), .m_wr(m_wr),
    .m_busy(m_busy), .m_done(m_done), .m_rdata(m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    if_req      = 1'b0;
    if_addr     = '0;
    flush_fetch = 1'b0;
    dm_rd       = 1'b0;
    dm_wr       = 1'b0;
    dm_addr     = '0;
    dm_wdata    = '0;
    m_busy      = 1'b0;
    m_done      = 1'b0;
    m_rdata     = '0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    clear_inputs();
    rst = 1'b1;

    // Reset with requests active: everything must stay quiet.
    tick();
    if_req = 1'b1; if_addr = 16'h0010; dm_rd = 1'b1; dm_addr = 16'h0200;
    settle();
    check("rst_m_rd",        m_rd,        0);
    check("rst_m_addr",      m_addr,      0);
    check("rst_stall_fetch", stall_fetch, 0);
    check("rst_stall_mem",   stall_mem,   0);

    tick();
    rst = 1'b0;
    clear_inputs();
    settle();
    check("idle_m_rd", m_rd, 0);

    // Lone fetch, memory answers 3 cycles after the command.
    tick();
    if_req = 1'b1; if_addr = 16'h0010;
    settle();
    check("lf_c0_m_rd",   m_rd,        1);
    check("lf_c0_m_addr", m_addr,      16'h0010);
    check("lf_c0_stall",  stall_fetch, 1);
    tick(); settle();
    check("lf_c1_m_rd",   m_rd,        0);
    check("lf_c1_m_addr", m_addr,      16'h0010);
    check("lf_c1_stall",  stall_fetch, 1);
    tick(); settle();
    check("lf_c2_stall",  stall_fetch, 1);
    tick();
    m_done = 1'b1; m_rdata = 16'hA5A5;
    settle();
    check("lf_c3_if_valid", if_valid,    1);
    check("lf_c3_if_data",  if_data,     16'hA5A5);
    check("lf_c3_stall",    stall_fetch, 0);
    tick();
    clear_inputs();
    settle();
    check("lf_after_if_valid", if_valid, 0);
    check("lf_after_if_data",  if_data,  0);

    // Contention: data wins, fetch follows the cycle after dm_valid.
    tick();
    if_req = 1'b1; if_addr = 16'h0020; dm_rd = 1'b1; dm_addr = 16'h0200;
    settle();
    check("ct_c0_m_rd",   m_rd,        1);
    check("ct_c0_m_addr", m_addr,      16'h0200);
    check("ct_c0_stf",    stall_fetch, 1);
    check("ct_c0_stm",    stall_mem,   1);
    tick(); settle();
    check("ct_c1_m_rd",   m_rd,        0);
    check("ct_c1_stf",    stall_fetch, 1);
    tick();
    m_done = 1'b1; m_rdata = 16'hBEEF;
    settle();
    check("ct_c2_dm_valid", dm_valid,    1);
    check("ct_c2_dm_rdata", dm_rdata,    16'hBEEF);
    check("ct_c2_stm",      stall_mem,   0);
    check("ct_c2_stf",      stall_fetch, 1);
    check("ct_c2_if_valid", if_valid,    0);
    tick();
    dm_rd = 1'b0; dm_addr = '0; m_done = 1'b0; m_rdata = '0;
    settle();
    check("ct_c3_m_rd",   m_rd,        1);
    check("ct_c3_m_addr", m_addr,      16'h0020);
    check("ct_c3_stf",    stall_fetch, 1);
    tick();
    m_done = 1'b1; m_rdata = 16'h1111;
    settle();
    check("ct_c4_if_valid", if_valid, 1);
    check("ct_c4_if_data",  if_data,  16'h1111);
    tick();
    clear_inputs();

    // Store.
    dm_wr = 1'b1; dm_addr = 16'h0042; dm_wdata = 16'h1234;
    settle();
    check("st_c0_m_wr",    m_wr,    1);
    check("st_c0_m_rd",    m_rd,    0);
    check("st_c0_m_addr",  m_addr,  16'h0042);
    check("st_c0_m_wdata", m_wdata, 16'h1234);
    tick(); settle();
    check("st_c1_m_wr",    m_wr,    0);
    check("st_c1_m_wdata", m_wdata, 16'h1234);
    check("st_c1_stm",     stall_mem, 1);
    tick();
    m_done = 1'b1; m_rdata = 16'hFFFF;
    settle();
    check("st_c2_dm_valid", dm_valid, 1);
    check("st_c2_dm_rdata", dm_rdata, 0);
    tick();
    clear_inputs();

    // Flush during an in-flight fetch.
    if_req = 1'b1; if_addr = 16'h0030;
    settle();
    check("fl_c0_m_rd", m_rd, 1);
    tick();
    flush_fetch = 1'b1;
    settle();
    check("fl_c1_m_rd", m_rd, 0);
    tick();
    flush_fetch = 1'b0; m_done = 1'b1; m_rdata = 16'hDEAD;
    settle();
    check("fl_c2_if_valid", if_valid,    0);
    check("fl_c2_if_data",  if_data,     0);
    check("fl_c2_stf",      stall_fetch, 1);
    tick();
    m_done = 1'b0; m_rdata = '0; if_addr = 16'h0034;
    settle();
    check("fl_c3_m_rd",   m_rd,   1);
    check("fl_c3_m_addr", m_addr, 16'h0034);
    tick();
    m_done = 1'b1; m_rdata = 16'h5678;
    settle();
    check("fl_c4_if_valid", if_valid, 1);
    check("fl_c4_if_data",  if_data,  16'h5678);
    tick();
    clear_inputs();

    // Fetch requested together with flush in IDLE: nothing issues.
    if_req = 1'b1; if_addr = 16'h0040; flush_fetch = 1'b1;
    settle();
    check("fi_m_rd", m_rd, 0);
    tick();
    clear_inputs();

    // Memory busy for 4 cycles with a data read pending.
    dm_rd = 1'b1; dm_addr = 16'h0080; m_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      check("mb_busy_m_rd", m_rd,      0);
      check("mb_busy_stm",  stall_mem, 1);
      tick();
    end
    m_busy = 1'b0;
    settle();
    check("mb_issue_m_rd",   m_rd,   1);
    check("mb_issue_m_addr", m_addr, 16'h0080);
    tick();
    m_done = 1'b1; m_rdata = 16'h0F0F;
    settle();
    check("mb_dm_valid", dm_valid, 1);
    check("mb_dm_rdata", dm_rdata, 16'h0F0F);
    tick();
    clear_inputs();

    // Stray m_done in IDLE.
    m_done = 1'b1; m_rdata = 16'h7777;
    settle();
    check("sd_if_valid", if_valid, 0);
    check("sd_dm_valid", dm_valid, 0);
    tick();
    clear_inputs();

    // Reset while in BUSY_D, then a late m_done.
    dm_rd = 1'b1; dm_addr = 16'h0099;
    settle();
    check("rm_c0_m_rd", m_rd, 1);
    tick();
    rst = 1'b1;
    settle();
    check("rm_rst_m_addr",   m_addr,      0);
    check("rm_rst_stm",      stall_mem,   0);
    check("rm_rst_stf",      stall_fetch, 0);
    check("rm_rst_m_rd",     m_rd,        0);
    tick();
    rst = 1'b0; dm_rd = 1'b0; dm_addr = '0;
    m_done = 1'b1; m_rdata = 16'hAAAA;
    settle();
    check("rm_post_dm_valid", dm_valid, 0);
    check("rm_post_dm_rdata", dm_rdata, 0);
    check("rm_post_m_addr",   m_addr,   0);
    tick();
    clear_inputs();
    settle();
    check("rm_idle_dm_valid", dm_valid, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
